imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch sequencer for the single-cycle/multicycle MIPS core. Owns the program counter, issues word requests to the instruction memory, holds the fetched word for the decode stage under a valid/ready handshake, and applies branch/jump redirects with squashing of stale responses. Sits between the PC-update logic of the datapath and the instruction memory's field splitter.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset (word-aligned)
- ADDR_W, 10, word-address width of instruction memory (1024 words)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- mem_req  out  1  request strobe to instruction memory
- mem_word_addr  out  ADDR_W  word index = pc[ADDR_W+1:2]
- mem_ack  in  1  memory response valid (may arrive 0..N cycles after mem_req)
- mem_rdata  in  32  instruction word, valid when mem_ack=1
- instr  out  32  held instruction to decode
- instr_pc  out  32  byte address of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode accepts when instr_valid & instr_ready
- branch_taken  in  1  redirect to branch_target (priority over jump)
- branch_target  in  32  byte target
- jump  in  1  redirect to {instr_pc+4 [31:28], jump_index, 2'b00}
- jump_index  in  26  J-format target field
- halt  in  1  stop issuing new requests
- fault  out  1  sticky: misaligned target or pc[31:ADDR_W+2] != 0

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALTED, FAULT.
- Reset (rst_n=0 at clk edge): pc=RESET_PC, state=IDLE, mem_req=0, instr=0, instr_pc=0, instr_valid=0, fault=0, squash=0.
- IDLE -> REQ next cycle unless halt.
- REQ: mem_req=1 for exactly one cycle with mem_word_addr from pc; -> WAIT. If mem_ack in same cycle (combinational memory), capture directly as in WAIT.
- WAIT: on mem_ack, if squash=0 latch instr=mem_rdata, instr_pc=pc, instr_valid=1, pc=pc+4, -> HOLD; if squash=1, drop data, clear squash, -> REQ at current pc.
- HOLD: on handshake, instr_valid=0 and -> REQ (or HALTED if halt). Otherwise hold instr/instr_pc stable.
- Redirect (branch_taken or jump, sampled any state except FAULT/reset): pc=target; instr_valid=0 next cycle; if in WAIT without ack this cycle, set squash=1; otherwise -> REQ. branch_taken wins when both asserted.
- Jump target uses instr_pc+4 of the currently held instruction (mod 2^32).
- Target check: target[1:0]!=0 or target beyond 2^(ADDR_W+2) bytes -> fault=1, state FAULT; no further mem_req until reset.
- pc increment wraps mod 2^32; increment past memory range raises fault on the next issue attempt.
- halt: completes any in-flight request (data still latched and presented), then HALTED; deassert halt -> REQ at pc.

## Timing
- Combinational memory (mem_ack tied to mem_req): reset release -> mem_req at cycle 1 -> instr_valid at cycle 2; sustained throughput 1 instr / 2 cycles with instr_ready=1.
- Memory latency L cycles: instr_valid asserted L+1 cycles after mem_req.
- Redirect at cycle t: instr_valid low at t+1; mem_req for target at t+1 (or after stale ack drains).
- All outputs registered; no combinational path from instr_ready to mem_req.
- Reset mid-WAIT: late mem_ack after reset release is ignored (state IDLE does not capture).

## Test plan
- Reset/boot: RESET_PC=0, memory words 0..3 = 0x20080005, 0x20090003, 0x01095020, 0x00000000, instr_ready=1 -> instr_pc 0,4,8,12 in order, correct words, instr_valid low during reset.
- Backpressure: instr_ready=0 for 5 cycles on pc=4 -> instr=0x20090003 stable, no mem_req, then single accept and fetch of pc=8.
- Branch squash: latency 3, branch_taken to 0x40 during WAIT -> in-flight word discarded, next valid instr_pc=0x40.
- Jump: held instr_pc=0x10, jump_index=0x000020 -> next instr_pc=0x80; branch_taken+jump same cycle -> branch_target wins.
- Fault: branch_target=0x42 -> fault=1 next cycle, mem_req never asserted again until rst_n low.
- Halt mid-fetch: halt during WAIT -> word presented, accepted, then HALTED with mem_req=0; release resumes at next pc.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_fetch_ctrl: PC owner and instruction-memory fetch sequencer with     |
// | valid/ready hand-off to decode and squashing branch/jump redirects.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_word_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              halt,
  output logic              fault
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_n, instr_pc_n;
  logic        valid_n, squash, squash_n;

  logic [31:0] jump_target, redirect_target;
  logic        redirect, target_bad, in_flight;

  function automatic logic out_of_range(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) != 32'd0;
  endfunction

  // Any attempt to start a new fetch goes through here so the range check
  // and halt gating are applied uniformly.
  function automatic state_t issue_to(input logic [31:0] a, input logic h);
    if (out_of_range(a)) return ST_FAULT;
    else if (h)          return ST_HALTED;
    else                 return ST_REQ;
  endfunction

  assign jump_target     = ((instr_pc + 32'd4) & 32'hF000_0000) | {4'b0000, jump_index, 2'b00};
  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target;
  assign target_bad      = (redirect_target[1:0] != 2'b00) | out_of_range(redirect_target);
  assign in_flight       = (state == ST_REQ) || (state == ST_WAIT);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    squash_n   = squash;

    if (state != ST_FAULT && redirect) begin
      pc_n    = redirect_target;
      valid_n = 1'b0;
      if (target_bad) begin
        state_n  = ST_FAULT;
        squash_n = 1'b0;
      end else if (in_flight && !mem_ack) begin
        // Response still owed by memory: wait it out and discard it.
        state_n  = ST_WAIT;
        squash_n = 1'b1;
      end else begin
        state_n  = halt ? ST_HALTED : ST_REQ;
        squash_n = 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE:   state_n = issue_to(pc, halt);
        ST_REQ, ST_WAIT: begin
          if (mem_ack) begin
            if (squash) begin
              squash_n = 1'b0;
              state_n  = issue_to(pc, halt);
            end else begin
              instr_n    = mem_rdata;
              instr_pc_n = pc;
              valid_n    = 1'b1;
              pc_n       = pc + 32'd4;
              state_n    = ST_HOLD;
            end
          end else begin
            state_n = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (instr_valid && instr_ready) begin
            valid_n = 1'b0;
            state_n = issue_to(pc, halt);
          end
        end
        ST_HALTED: if (!halt) state_n = issue_to(pc, 1'b0);
        ST_FAULT:  state_n = ST_FAULT;
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      instr         <= 32'd0;
      instr_pc      <= 32'd0;
      instr_valid   <= 1'b0;
      squash        <= 1'b0;
      fault         <= 1'b0;
      mem_req       <= 1'b0;
      mem_word_addr <= RESET_PC[ADDR_W+1:2];
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      instr         <= instr_n;
      instr_pc      <= instr_pc_n;
      instr_valid   <= valid_n;
      squash        <= squash_n;
      fault         <= fault | (state_n == ST_FAULT);
      // Request strobe is registered off the next state so it is high for
      // exactly the cycle spent in REQ.
      mem_req       <= (state_n == ST_REQ);
      mem_word_addr <= pc_n[ADDR_W+1:2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// Scoreboard bench for imem_fetch_ctrl: directed scenarios push expected
// (pc, word) pairs; a negedge monitor pops and compares on every accept.
module tb_imem_fetch_ctrl;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_word_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic              branch_taken = 1'b0;
  logic [31:0]       branch_target = 32'd0;
  logic              jump = 1'b0;
  logic [25:0]       jump_index = 26'd0;
  logic              halt = 1'b0;
  logic              fault;

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_word_addr(mem_word_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .halt(halt), .fault(fault)
  );

  always #5 clk = ~clk;

  // Instruction memory model: lat==0 is combinational, else ack lat cycles later.
  logic [31:0]       mem [0:1023];
  int                lat = 0;
  int                pend = 0;
  logic [ADDR_W-1:0] paddr = '0;

  always @(posedge clk) begin
    if (!rst_n)                   pend <= 0;
    else if (mem_req && lat > 0) begin
      pend  <= lat;
      paddr <= mem_word_addr;
    end else if (pend > 0)        pend <= pend - 1;
  end
  assign mem_ack   = (lat == 0) ? mem_req : (pend == 1);
  assign mem_rdata = mem[(lat == 0) ? mem_word_addr : paddr];

  typedef struct packed { logic [31:0] pc; logic [31:0] w; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   req_cnt = 0;

  always @(negedge clk) begin
    if (mem_req) req_cnt++;
    if (rst_n && instr_valid && instr_ready) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL accept: got pc=%h instr=%h, expected no instruction", instr_pc, instr);
      end else begin
        mon_e = sbq.pop_front();
        if (instr_pc !== mon_e.pc || instr !== mon_e.w) begin
          fails++;
          $display("FAIL accept: got pc=%h instr=%h, expected pc=%h instr=%h",
                   instr_pc, instr, mon_e.pc, mon_e.w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] w);
    sbq.push_back({a, w});
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected instructions not delivered, expected 0", sbq.size());
      sbq.delete();
    end
    instr_ready = 1'b0;
  endtask

  task automatic wait_held(input logic [31:0] a);
    int n = 0;
    while (!(instr_valid && instr_pc == a) && n < 40) begin
      tick();
      n++;
    end
    check("held pc", instr_valid ? instr_pc : 32'hDEAD_DEAD, a);
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    halt = 1'b0;
    instr_ready = 1'b0;
    lat = l;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_0000;

    // Boot: reset state, first-fetch timing, four sequential words.
    do_reset(0);
    check("rst valid", instr_valid, 0);
    check("rst mem_req", mem_req, 0);
    check("rst fault", fault, 0);
    check("rst instr", instr, 0);
    check("rst instr_pc", instr_pc, 0);
    instr_ready = 1'b1;
    push(32'h0, 32'h2008_0005);
    push(32'h4, 32'h2009_0003);
    push(32'h8, 32'h0109_5020);
    push(32'hC, 32'h0000_0000);
    rst_n = 1'b1;
    tick();
    check("boot mem_req c1", mem_req, 1);
    check("boot addr c1", 32'(mem_word_addr), 0);
    tick();
    check("boot valid c2", instr_valid, 1);
    drain(40);

    // Backpressure on pc=4.
    do_reset(0);
    instr_ready = 1'b1;
    push(32'h0, 32'h2008_0005);
    push(32'h4, 32'h2009_0003);
    push(32'h8, 32'h0109_5020);
    rst_n = 1'b1;
    for (int n = 0; n < 20 && sbq.size() != 2; n++) tick();
    instr_ready = 1'b0;
    tick();
    rc = req_cnt;
    for (int k = 0; k < 5; k++) begin
      check("bp instr", instr, 32'h2009_0003);
      check("bp pc", instr_pc, 32'h4);
      check("bp valid", instr_valid, 1);
      tick();
    end
    check("bp no mem_req", 32'(req_cnt), 32'(rc));
    instr_ready = 1'b1;
    drain(40);

    // Branch during WAIT with latency 3 squashes the in-flight word.
    do_reset(3);
    instr_ready = 1'b1;
    push(32'h40, 32'hA000_0010);
    rst_n = 1'b1;
    tick();
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    check("squash valid low", instr_valid, 0);
    drain(60);
    check("squash fault", fault, 0);

    // Jump from held pc 0x10, then branch+jump together.
    do_reset(0);
    instr_ready = 1'b1;
    push(32'h0, 32'h2008_0005);
    push(32'h4, 32'h2009_0003);
    push(32'h8, 32'h0109_5020);
    push(32'hC, 32'h0000_0000);
    rst_n = 1'b1;
    drain(40);
    wait_held(32'h10);
    check("held instr 0x10", instr, 32'hA000_0004);
    jump = 1'b1;
    jump_index = 26'h20;
    tick();
    jump = 1'b0;
    check("jump valid low", instr_valid, 0);
    push(32'h80, 32'hA000_0020);
    instr_ready = 1'b1;
    drain(40);
    wait_held(32'h84);
    branch_taken = 1'b1;
    branch_target = 32'h100;
    jump = 1'b1;
    jump_index = 26'h20;
    tick();
    branch_taken = 1'b0;
    jump = 1'b0;
    push(32'h100, 32'hA000_0040);
    instr_ready = 1'b1;
    drain(40);

    // Misaligned branch target faults and stops all requests.
    do_reset(0);
    rst_n = 1'b1;
    wait_held(32'h0);
    branch_taken = 1'b1;
    branch_target = 32'h42;
    tick();
    branch_taken = 1'b0;
    check("misalign fault", fault, 1);
    check("misalign valid", instr_valid, 0);
    instr_ready = 1'b1;
    tick();
    rc = req_cnt;
    repeat (20) tick();
    check("fault no mem_req", 32'(req_cnt), 32'(rc));
    check("fault sticky", fault, 1);
    instr_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check("fault cleared by reset", fault, 0);

    // Target just beyond memory range faults.
    do_reset(0);
    rst_n = 1'b1;
    wait_held(32'h0);
    branch_taken = 1'b1;
    branch_target = 32'h1000;
    tick();
    branch_taken = 1'b0;
    check("range fault", fault, 1);

    // Last word in range fetches; incrementing past it faults on next issue.
    do_reset(0);
    rst_n = 1'b1;
    wait_held(32'h0);
    branch_taken = 1'b1;
    branch_target = 32'hFFC;
    tick();
    branch_taken = 1'b0;
    check("last word no fault", fault, 0);
    push(32'hFFC, 32'hA000_03FF);
    instr_ready = 1'b1;
    drain(40);
    tick();
    check("wrap fault", fault, 1);
    rc = req_cnt;
    repeat (5) tick();
    check("wrap no mem_req", 32'(req_cnt), 32'(rc));

    // Halt during WAIT: word still delivered, then idle until release.
    do_reset(2);
    instr_ready = 1'b1;
    push(32'h0, 32'h2008_0005);
    rst_n = 1'b1;
    tick();
    tick();
    halt = 1'b1;
    drain(40);
    tick();
    rc = req_cnt;
    repeat (6) tick();
    check("halt no mem_req", 32'(req_cnt), 32'(rc));
    check("halt mem_req low", mem_req, 0);
    check("halt valid low", instr_valid, 0);
    halt = 1'b0;
    push(32'h4, 32'h2009_0003);
    instr_ready = 1'b1;
    drain(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
